fpu_vector_checker: RTL and testbench

- Synthesizable self-test sequencer for the `fpu` core.
- It holds a loadable table of DEPTH test vectors: operation, rounding mode, opa, opb and expected result.
- On `start` it issues the vectors back-to-back into the FPU operand/op ports and aligns each expected value with the FPU output via a LAT-deep tag pipeline.
- It compares each result with optional ULP tolerance and reports pass/fail counts plus the first failing index.
- It replaces the hand-written single-vector `$monitor` harness with a parametrised, on-chip checker.

---
 rtl/fpu_chk_pkg.sv | 36 +++
 rtl/fpu_vector_checker_compare.sv | 39 +++
 rtl/fpu_vector_checker.sv | 162 ++++++++++++++++
 tb/tb_fpu_vector_checker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_chk_pkg.sv
// Shared definitions for the FPU self-test sequencer: op/rounding codes,
// IEEE-754 single field sizes, the expected-value tag and the FSM states.
package fpu_chk_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RZ  = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  // Tag fields are sized for the widest supported configuration.
  localparam int TAG_IDX_W  = 8;
  localparam int TAG_DATA_W = 32;

  typedef struct packed {
    logic                  vld;
    logic [TAG_IDX_W-1:0]  idx;
    logic [TAG_DATA_W-1:0] exp_val;
  } chk_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/fpu_vector_checker_compare.sv
// Result-versus-expected compare with NaN/zero handling and ULP tolerance
// measured on the sign-less magnitude.
module fpu_ulp_compare
  import fpu_chk_pkg::*;
#(
  parameter int W       = 32,
  parameter int ULP_TOL = 0
) (
  input  logic [W-1:0] result,
  input  logic [W-1:0] exp_val,
  output logic         match
);

  localparam int MW = W - 1 - EXP_W;

  logic [W-2:0] mag_r;
  logic [W-2:0] mag_e;
  logic [W-2:0] diff;
  logic         exp_nan;
  logic         res_nan;

  always_comb begin
    mag_r   = result[W-2:0];
    mag_e   = exp_val[W-2:0];
    diff    = (mag_r >= mag_e) ? (mag_r - mag_e) : (mag_e - mag_r);
    exp_nan = (&exp_val[W-2 -: EXP_W]) && (|exp_val[MW-1:0]);
    res_nan = (&result[W-2 -: EXP_W]) && (|result[MW-1:0]);
    match   = 1'b0;
    if (exp_nan)
      match = res_nan;
    else if (mag_r == '0 && mag_e == '0)
      match = 1'b1;
    else if (result[W-1] != exp_val[W-1])
      match = 1'b0;
    else
      match = (diff <= (W-1)'(ULP_TOL));
  end

endmodule

// File: rtl/fpu_vector_checker.sv
// Self-test sequencer: streams a loaded vector table into the FPU and checks
// each result against its expected value carried down a LAT-deep tag pipe.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_ISSUE | driving one vector per cycle into the FPU
//   ST_DRAIN | all vectors issued, waiting for the last result
//   ST_DONE  | results final, done held until next start
module fpu_vector_checker
  import fpu_chk_pkg::*;
#(
  parameter int W       = 32,
  parameter int DEPTH   = 16,
  parameter int LAT     = 4,
  parameter int ULP_TOL = 0,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_op,
  input  logic [1:0]    wr_rmode,
  input  logic [W-1:0]  wr_opa,
  input  logic [W-1:0]  wr_opb,
  input  logic [W-1:0]  wr_expect,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  output logic [2:0]    fpu_op,
  output logic [1:0]    fpu_rmode,
  output logic [W-1:0]  opa,
  output logic [W-1:0]  opb,
  input  logic [W-1:0]  fpu_out,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   pass_cnt,
  output logic [AW:0]   fail_cnt,
  output logic [AW-1:0] first_fail_idx,
  output logic          first_fail_vld
);

  logic [2:0]   mem_op  [DEPTH];
  logic [1:0]   mem_rm  [DEPTH];
  logic [W-1:0] mem_opa [DEPTH];
  logic [W-1:0] mem_opb [DEPTH];
  logic [W-1:0] mem_exp [DEPTH];

  chk_state_t   state;
  logic [AW-1:0] issue_idx;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   nv_sat;
  chk_tag_t      tag_pipe [LAT];
  chk_tag_t      head;
  logic          head_match;

  function automatic chk_tag_t mk_tag(input logic [AW-1:0] idx, input logic [W-1:0] ev);
    chk_tag_t t;
    t.vld     = 1'b1;
    t.idx     = TAG_IDX_W'(idx);
    t.exp_val = TAG_DATA_W'(ev);
    return t;
  endfunction

  // Vector table is deliberately not reset so it survives a run abort.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_op[wr_addr]  <= wr_op;
      mem_rm[wr_addr]  <= wr_rmode;
      mem_opa[wr_addr] <= wr_opa;
      mem_opb[wr_addr] <= wr_opb;
      mem_exp[wr_addr] <= wr_expect;
    end
  end

  assign nv_sat = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  assign rd_idx = (state == ST_ISSUE) ? issue_idx : '0;
  assign head   = tag_pipe[LAT-1];

  fpu_ulp_compare #(.W(W), .ULP_TOL(ULP_TOL)) u_cmp (
    .result  (fpu_out),
    .exp_val (head.exp_val[W-1:0]),
    .match   (head_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      issue_idx      <= '0;
      last_idx       <= '0;
      fpu_op         <= '0;
      fpu_rmode      <= '0;
      opa            <= '0;
      opb            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '0;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (head.vld) begin
        if (head_match) begin
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          fail_cnt <= fail_cnt + 1'b1;
          if (!first_fail_vld) begin
            first_fail_idx <= head.idx[AW-1:0];
            first_fail_vld <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) done <= 1'b1;
          // Clearing here overrides any compare update above on the same edge.
          if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            done           <= 1'b0;
            if (nv_sat == '0) begin
              state <= ST_DONE;
            end else begin
              busy        <= 1'b1;
              fpu_op      <= mem_op[rd_idx];
              fpu_rmode   <= mem_rm[rd_idx];
              opa         <= mem_opa[rd_idx];
              opb         <= mem_opb[rd_idx];
              tag_pipe[0] <= mk_tag(rd_idx, mem_exp[rd_idx]);
              last_idx    <= AW'(nv_sat - 1'b1);
              issue_idx   <= AW'(1);
              state       <= (nv_sat == (AW+1)'(1)) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          fpu_op      <= mem_op[rd_idx];
          fpu_rmode   <= mem_rm[rd_idx];
          opa         <= mem_opa[rd_idx];
          opb         <= mem_opb[rd_idx];
          tag_pipe[0] <= mk_tag(rd_idx, mem_exp[rd_idx]);
          issue_idx   <= issue_idx + 1'b1;
          if (issue_idx == last_idx) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (head.vld && head.idx == TAG_IDX_W'(last_idx)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Randomised bench: two checkers (ULP tolerance 0 and 1) run against a
// behavioural FPU and a run-level reference model of the expected counts.
module tb_fpu_vector_checker;
  import fpu_chk_pkg::*;

  localparam int W = 32, DEPTH = 16, LAT = 4, AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0] wr_op = '0;
  logic [1:0] wr_rmode = '0;
  logic [W-1:0] wr_opa = '0, wr_opb = '0, wr_expect = '0;
  logic [AW:0] num_vec = '0;

  logic [2:0] fpu_op0, fpu_op1;
  logic [1:0] fpu_rmode0, fpu_rmode1;
  logic [W-1:0] opa0, opb0, opa1, opb1, fpu_out0, fpu_out1;
  logic busy0, busy1, done0, done1, ffv0, ffv1;
  logic [AW:0] pass0, pass1, fail0, fail1;
  logic [AW-1:0] ffi0, ffi1;

  logic [W-1:0] fp0 [LAT-1];
  logic [W-1:0] fp1 [LAT-1];

  logic [2:0]  t_op [DEPTH];
  logic [1:0]  t_rm [DEPTH];
  logic [31:0] t_a [DEPTH], t_b [DEPTH], t_e [DEPTH];

  logic [2:0]  ovr_op [8];
  logic [31:0] ovr_a [8], ovr_b [8], ovr_r [8];
  int ovr_n = 0;

  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  fpu_vector_checker #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .ULP_TOL(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
    .wr_rmode(wr_rmode), .wr_opa(wr_opa), .wr_opb(wr_opb), .wr_expect(wr_expect),
    .num_vec(num_vec), .start(start), .fpu_op(fpu_op0), .fpu_rmode(fpu_rmode0),
    .opa(opa0), .opb(opb0), .fpu_out(fpu_out0), .busy(busy0), .done(done0),
    .pass_cnt(pass0), .fail_cnt(fail0), .first_fail_idx(ffi0), .first_fail_vld(ffv0));

  fpu_vector_checker #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .ULP_TOL(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
    .wr_rmode(wr_rmode), .wr_opa(wr_opa), .wr_opb(wr_opb), .wr_expect(wr_expect),
    .num_vec(num_vec), .start(start), .fpu_op(fpu_op1), .fpu_rmode(fpu_rmode1),
    .opa(opa1), .opb(opb1), .fpu_out(fpu_out1), .busy(busy1), .done(done1),
    .pass_cnt(pass1), .fail_cnt(fail1), .first_fail_idx(ffi1), .first_fail_vld(ffv1));

  // Behavioural FPU: a lookup of known results, otherwise a finite hash.
  function automatic logic [31:0] fpu_calc(input logic [2:0] op, input logic [1:0] rm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    for (int i = 0; i < ovr_n; i++)
      if (op == ovr_op[i] && a == ovr_a[i] && b == ovr_b[i]) return ovr_r[i];
    t = a ^ {b[15:0], b[31:16]} ^ {27'd0, op, rm};
    t[30] = 1'b0;
    return t;
  endfunction

  // Operands registered by the checker plus LAT-1 internal stages = LAT.
  always @(posedge clk) begin
    fp0[0] <= fpu_calc(fpu_op0, fpu_rmode0, opa0, opb0);
    fp1[0] <= fpu_calc(fpu_op1, fpu_rmode1, opa1, opb1);
    for (int i = 1; i < LAT-1; i++) begin
      fp0[i] <= fp0[i-1];
      fp1[i] <= fp1[i-1];
    end
  end
  assign fpu_out0 = fp0[LAT-2];
  assign fpu_out1 = fp1[LAT-2];

  function automatic bit ref_match(input logic [31:0] r, input logic [31:0] e, input int tol);
    bit e_nan, r_nan;
    longint mr, me, d;
    e_nan = (e[30:23] == 8'hff) && (e[22:0] != 0);
    r_nan = (r[30:23] == 8'hff) && (r[22:0] != 0);
    mr = longint'(r[30:0]);
    me = longint'(e[30:0]);
    if (e_nan) return r_nan;
    if (mr == 0 && me == 0) return 1'b1;
    if (r[31] != e[31]) return 1'b0;
    d = (mr > me) ? mr - me : me - mr;
    return d <= tol;
  endfunction

  task automatic model(input int nv, input int tol, output int p, output int f,
                       output int fi, output bit fv);
    p = 0; f = 0; fi = 0; fv = 1'b0;
    for (int i = 0; i < nv; i++) begin
      if (ref_match(fpu_calc(t_op[i], t_rm[i], t_a[i], t_b[i]), t_e[i], tol)) p++;
      else begin
        f++;
        if (!fv) begin fv = 1'b1; fi = i; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input int i, input logic [2:0] op, input logic [1:0] rm,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    t_op[i] = op; t_rm[i] = rm; t_a[i] = a; t_b[i] = b; t_e[i] = e;
    wr_en = 1'b1; wr_addr = AW'(i); wr_op = op; wr_rmode = rm;
    wr_opa = a; wr_opb = b; wr_expect = e;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic add_ovr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
    ovr_op[ovr_n] = op; ovr_a[ovr_n] = a; ovr_b[ovr_n] = b; ovr_r[ovr_n] = r;
    ovr_n++;
  endtask

  task automatic rand_vec(input int i, input int pert);
    logic [2:0] op;
    logic [1:0] rm;
    logic [31:0] a, b, e;
    op = 3'($urandom_range(0, 3));
    rm = 2'($urandom_range(0, 3));
    a = $urandom; b = $urandom;
    e = fpu_calc(op, rm, a, b);
    case (pert)
      2: e = e + 32'd1;
      3: e = (e[30:0] == 0) ? e + 32'd1 : e - 32'd1;
      4: e = e ^ 32'h8000_0000;
      5: e = e + 32'd2;
      6: e = e + 32'd5;
      default: ;
    endcase
    write_vec(i, op, rm, a, b, e);
  endtask

  task automatic run_check(input string name, input int nv, input bit disturb);
    int nve, exp_len, edges, p0, f0, fi0, p1, f1, fi1;
    bit fv0, fv1;
    nve = (nv > DEPTH) ? DEPTH : nv;
    exp_len = (nve == 0) ? 1 : nve + LAT - 1;
    model(nve, 0, p0, f0, fi0, fv0);
    model(nve, 1, p1, f1, fi1, fv1);
    num_vec = (AW+1)'(nv);
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    while (done0 !== 1'b1 && edges < 200) begin
      n_vec++;
      if (busy0 !== (nve > 0) || busy1 !== (nve > 0) || done1 !== 1'b0) begin
        n_miss++;
        $display("FAIL %s busy: busy0=%b busy1=%b done1=%b, required busy=%0d done=0 at edge %0d",
                 name, busy0, busy1, done1, nve > 0, edges);
      end
      if (edges < nve) begin
        n_vec++;
        if ({fpu_op0, fpu_rmode0, opa0, opb0} !== {t_op[edges], t_rm[edges], t_a[edges], t_b[edges]} ||
            {fpu_op1, fpu_rmode1, opa1, opb1} !== {t_op[edges], t_rm[edges], t_a[edges], t_b[edges]}) begin
          n_miss++;
          $display("FAIL %s issue[%0d]: op=%0d rm=%0d opa=%h opb=%h, required op=%0d rm=%0d opa=%h opb=%h",
                   name, edges, fpu_op0, fpu_rmode0, opa0, opb0,
                   t_op[edges], t_rm[edges], t_a[edges], t_b[edges]);
        end
      end
      if (disturb && edges == 2) begin
        start = 1'b1; num_vec = 1; wr_en = 1'b1; wr_addr = '0;
        wr_opa = 32'hdead_beef; wr_expect = 32'h1234_5678;
      end
      tick();
      edges++;
      start = 1'b0;
      wr_en = 1'b0;
    end
    n_vec++;
    if (edges != exp_len) begin
      n_miss++;
      $display("FAIL %s run_len: %0d edges, required %0d", name, edges, exp_len);
    end
    n_vec++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b1) begin
      n_miss++;
      $display("FAIL %s end_flags: busy0=%b busy1=%b done1=%b, required 0 0 1",
               name, busy0, busy1, done1);
    end
    n_vec++;
    if (pass0 !== (AW+1)'(p0) || fail0 !== (AW+1)'(f0) || ffv0 !== fv0 ||
        (fv0 && ffi0 !== AW'(fi0))) begin
      n_miss++;
      $display("FAIL %s tol0: pass=%0d fail=%0d ffv=%b ffi=%0d, required %0d %0d %b %0d",
               name, pass0, fail0, ffv0, ffi0, p0, f0, fv0, fi0);
    end
    n_vec++;
    if (pass1 !== (AW+1)'(p1) || fail1 !== (AW+1)'(f1) || ffv1 !== fv1 ||
        (fv1 && ffi1 !== AW'(fi1))) begin
      n_miss++;
      $display("FAIL %s tol1: pass=%0d fail=%0d ffv=%b ffi=%0d, required %0d %0d %b %0d",
               name, pass1, fail1, ffv1, ffi1, p1, f1, fv1, fi1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if ({busy0, done0, pass0, fail0, ffi0, ffv0, fpu_op0, fpu_rmode0, opa0, opb0} !== '0 ||
        {busy1, done1, pass1, fail1, ffi1, ffv1, fpu_op1, fpu_rmode1, opa1, opb1} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%0d fail=%0d opa=%h op=%0d, required all 0",
               busy0, done0, pass0, fail0, opa0, fpu_op0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    add_ovr(OP_ADD, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0000);
    add_ovr(OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40c0_0000);
    write_vec(0, OP_ADD, RM_RNE, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0000);
    write_vec(1, OP_MUL, RM_RZ,  32'h4000_0000, 32'h4040_0000, 32'h40c0_0000);
    run_check("directed", 2, 1'b0);
  endtask

  task automatic test_ulp();
    write_vec(0, OP_ADD, RM_RNE, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0001);
    run_check("ulp", 1, 1'b0);
  endtask

  task automatic test_compare_rules();
    add_ovr(OP_ADD, 32'h1111_0000, 32'h0, 32'h7fc0_0001);
    add_ovr(OP_ADD, 32'h1111_0001, 32'h0, 32'h0000_0000);
    add_ovr(OP_ADD, 32'h1111_0002, 32'h0, 32'hbf80_0000);
    add_ovr(OP_ADD, 32'h1111_0003, 32'h0, 32'h7f80_0000);
    add_ovr(OP_ADD, 32'h1111_0004, 32'h0, 32'h3f80_0002);
    write_vec(0, OP_ADD, RM_RUP, 32'h1111_0000, 32'h0, QNAN);
    write_vec(1, OP_ADD, RM_RUP, 32'h1111_0001, 32'h0, 32'h8000_0000);
    write_vec(2, OP_ADD, RM_RUP, 32'h1111_0002, 32'h0, 32'h3f80_0000);
    write_vec(3, OP_ADD, RM_RDN, 32'h1111_0003, 32'h0, 32'hff80_0000);
    write_vec(4, OP_ADD, RM_RDN, 32'h1111_0004, 32'h0, 32'h3f80_0001);
    run_check("compare_rules", 5, 1'b0);
  endtask

  task automatic test_zero_vec();
    run_check("zero_vec", 0, 1'b0);
  endtask

  task automatic test_full_mismatch();
    for (int i = 0; i < DEPTH; i++) rand_vec(i, (i == 3 || i == 9) ? 6 : 0);
    run_check("full_mismatch", DEPTH, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_check("back_to_back", DEPTH, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) rand_vec(i, $urandom_range(0, 5));
    run_check("saturate", 20, 1'b0);
    for (int r = 0; r < 3; r++) run_check("random", $urandom_range(1, DEPTH), 1'b0);
  endtask

  task automatic test_reset_mid_run();
    num_vec = DEPTH;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({busy0, done0, pass0, fail0, ffv0, opa0} !== '0 ||
        {busy1, done1, pass1, fail1, ffv1, opa1} !== '0) begin
      n_miss++;
      $display("FAIL reset_mid_run: busy=%b done=%b pass=%0d fail=%0d opa=%h, required all 0",
               busy0, done0, pass0, fail0, opa0);
    end
    rst = 1'b0;
    tick();
    run_check("rerun", DEPTH, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ulp();
    test_compare_rules();
    test_zero_vec();
    test_full_mismatch();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
